// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory responder. It handles word, half and byte
// loads with sign or zero extension, sub-word stores as read-modify-write, and traps misaligned requests.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_ena_i,
  input  logic        dmem_wena_i,
  input  logic [1:0]  dmem_type_i,
  input  logic        ext_signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        misalign_o
);
  typedef enum logic [2:0] {IDLE, RD, RESP, WR, MERGE, ERR} state_t;
  localparam logic [1:0] T_WORD = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_BYTE = 2'b10;

  state_t            state_reg, state_next;
  logic [1:0]        type_reg;
  logic              wena_reg;
  logic              signed_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_q;
  logic [ADDR_W-1:0] word_idx;
  logic              accept;
  logic              misaligned;
  logic              mem_we;
  logic [7:0]        rd_byte [4];
  logic [3:0]        lane_en;
  logic [31:0]       merged;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;

  // Address bits above the array size deliberately alias; only kept to document that.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

  assign accept     = (state_reg == IDLE) && dmem_ena_i;
  assign misaligned = (dmem_type_i == T_WORD && addr_i[1:0] != 2'b00) ||
                      (dmem_type_i == T_HALF && addr_i[0]) ||
                      (dmem_type_i == 2'b11);
  assign word_idx   = addr_reg[ADDR_W+1:2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      type_reg   <= T_WORD;
      wena_reg   <= 1'b0;
      signed_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        type_reg   <= dmem_type_i;
        wena_reg   <= dmem_wena_i;
        signed_reg <= ext_signed_i;
        addr_reg   <= addr_i[ADDR_W+1:0];
        wdata_reg  <= wdata_i;
      end
      if (state_reg == RESP) rdata_reg <= load_ext;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (dmem_ena_i) begin
          if (misaligned)                              state_next = ERR;
          else if (dmem_wena_i && dmem_type_i == T_WORD) state_next = WR;
          else                                         state_next = RD;
        end
      end
      RD:      state_next = wena_reg ? MERGE : RESP;
      RESP, WR, MERGE, ERR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done_o     = (state_reg == RESP) || (state_reg == WR) ||
                 (state_reg == MERGE) || (state_reg == ERR);
    rvalid_o   = (state_reg == RESP);
    misalign_o = (state_reg == ERR);
    mem_we     = (state_reg == WR) || (state_reg == MERGE);
    stall_o    = ((state_reg != IDLE) && !done_o) || ((state_reg == IDLE) && dmem_ena_i);
    // The load result is visible during RESP itself, then held by rdata_reg.
    rdata_o    = (state_reg == RESP) ? load_ext : rdata_reg;
  end

  // Array is never reset; the write is gated by state so a reset before the edge cancels it.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[word_idx] <= merged;
    if (state_reg == RD) rd_q <= mem[word_idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_data;
      assign rd_byte[gi] = rd_q[8*gi +: 8];
      assign lane_en[gi] = (type_reg == T_WORD) ||
                           (type_reg == T_HALF && addr_reg[1] == 1'(gi / 2)) ||
                           (type_reg == T_BYTE && addr_reg[1:0] == 2'(gi));
      // Sub-word payloads sit in the low bits of the store data.
      assign lane_data = (type_reg == T_BYTE) ? wdata_reg[7:0] :
                         (type_reg == T_HALF) ? wdata_reg[8*(gi%2) +: 8] :
                                                wdata_reg[8*gi +: 8];
      assign merged[8*gi +: 8] = lane_en[gi] ? lane_data : rd_byte[gi];
    end
  endgenerate

  always_comb begin
    byte_sel = rd_byte[addr_reg[1:0]];
    half_sel = addr_reg[1] ? rd_q[31:16] : rd_q[15:0];
    unique case (type_reg)
      T_BYTE:  load_ext = {{24{signed_reg & byte_sel[7]}}, byte_sel};
      T_HALF:  load_ext = {{16{signed_reg & half_sel[15]}}, half_sel};
      default: load_ext = rd_q;
    endcase
  end
endmodule
